// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-side signals for mem_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 req0;
  logic                 req1;
  logic [WORD_SIZE-1:0] addr0;
  logic [WORD_SIZE-1:0] addr1;
  logic                 we0;
  logic                 we1;
  logic [WORD_SIZE-1:0] wdata0;
  logic [WORD_SIZE-1:0] wdata1;
  logic                 ack0;
  logic                 ack1;
  logic                 err0;
  logic                 err1;
  logic [WORD_SIZE-1:0] rdata;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ready;
  logic                 busy;

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ready,
    output ack0, ack1, err0, err1, rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ready,
    input  ack0, ack1, err0, err1, rdata, mem_req, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between fetch (port 0)
// and load/store (port 1), with a WAIT-state timeout that reports an error to the owner.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int            CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 err0_q, err0_d;
  logic                 err1_q, err1_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // A tie goes to the port that did not win last time.
          owner_d     = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          mem_addr_d  = owner_d ? bus.addr1  : bus.addr0;
          mem_we_d    = owner_d ? bus.we1    : bus.we0;
          mem_wdata_d = owner_d ? bus.wdata1 : bus.wdata0;
          mem_req_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // mem_ready takes precedence over the timeout on the limit edge.
        if (bus.mem_ready || (cnt_q == CNT_LIMIT)) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          err0_d  = ~bus.mem_ready & ~owner_q;
          err1_d  = ~bus.mem_ready & owner_q;
          rdata_d = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory model answers mem_req after a
// programmable number of cycles (0 = never), and each task checks one behaviour.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Memory model controls
  int          mem_lat     = 0;
  logic [15:0] mem_val     = 16'h0000;
  logic        inject_rdy  = 1'b0;

  mem_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_arbiter #(.WORD_SIZE(16), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: mem_req seen in ISSUE -> mem_ready during the mem_lat-th WAIT cycle.
  initial begin
    int cnt;
    cnt = -1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (inject_rdy) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_val;
        inject_rdy    = 1'b0;
      end
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_val;
          cnt = -1;
        end
      end
      if (bus.mem_req && mem_lat > 0) cnt = mem_lat;
    end
  end

  task automatic wait_ack(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_req, bus.mem_we, bus.busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_req, bus.mem_we, bus.busy});
    end
    total++;
    if ({bus.rdata, bus.mem_addr, bus.mem_wdata} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.rdata, bus.mem_addr, bus.mem_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    int cyc;
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'd5; bus.we0 = 1'b0;
    mem_lat = 1; mem_val = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_we, bus.busy, bus.mem_addr} !== {3'b101, 16'd5}) begin
      bad++;
      $display("FAIL read_issue: got req/we/busy/addr %b%b%b/%h want 101/0005",
               bus.mem_req, bus.mem_we, bus.busy, bus.mem_addr);
    end
    wait_ack(10, cyc);
    total++;
    if (cyc !== 2) begin
      bad++;
      $display("FAIL read_latency: got %0d want 2", cyc);
    end
    total++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.rdata} !== {3'b100, 16'hBEEF}) begin
      bad++;
      $display("FAIL read_ack: got ack0/ack1/err0/rdata %b%b%b/%h want 100/beef",
               bus.ack0, bus.ack1, bus.err0, bus.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.ack0, bus.busy, bus.rdata} !== {2'b00, 16'hBEEF}) begin
      bad++;
      $display("FAIL read_after: got ack0/busy/rdata %b%b/%h want 00/beef",
               bus.ack0, bus.busy, bus.rdata);
    end
  endtask

  task automatic test_alternate();
    int cyc;
    logic [1:0] exp_ack;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 16'd10; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 16'd20; bus.we1 = 1'b0;
    mem_lat = 1; mem_val = 16'h0A0A;
    for (int t = 0; t < 4; t++) begin
      wait_ack(12, cyc);
      exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if ({bus.ack1, bus.ack0} !== exp_ack) begin
        bad++;
        $display("FAIL alt_order[%0d]: got ack1ack0=%b want %b", t, {bus.ack1, bus.ack0}, exp_ack);
      end
      total++;
      if (cyc !== ((t == 0) ? 3 : 4)) begin
        bad++;
        $display("FAIL alt_cycles[%0d]: got %0d want %0d", t, cyc, (t == 0) ? 3 : 4);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int waits;
    logic got;
    @(negedge clk);
    bus.req1 = 1'b1; bus.addr1 = 16'd3; bus.we1 = 1'b1; bus.wdata1 = 16'h1234;
    mem_lat = 3; mem_val = 16'h5555;
    @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 16'd3, 16'h1234}) begin
      bad++;
      $display("FAIL write_issue: got req/we/addr/wdata %b%b/%h/%h want 11/0003/1234",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        got = 1'b1;
        break;
      end
      waits++;
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b01, 16'd3, 16'h1234}) begin
        bad++;
        $display("FAIL write_hold[%0d]: got req/we/addr/wdata %b%b/%h/%h want 01/0003/1234",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    total++;
    if ({got, waits[3:0]} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL write_waits: got ack=%b waits=%0d want ack=1 waits=3", got, waits);
    end
    total++;
    if ({bus.ack1, bus.ack0, bus.err1, bus.rdata} !== {3'b100, 16'h0000}) begin
      bad++;
      $display("FAIL write_ack: got ack1/ack0/err1/rdata %b%b%b/%h want 100/0000",
               bus.ack1, bus.ack0, bus.err1, bus.rdata);
    end
    bus.req1 = 1'b0;
    bus.we1  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout(input int lat, input logic exp_err, input logic [15:0] exp_rd);
    int waits;
    logic got;
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'd7; bus.we0 = 1'b0;
    mem_lat = lat; mem_val = 16'hC0DE;
    @(negedge clk);
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    total++;
    if ({got, waits[4:0]} !== {1'b1, 5'd8}) begin
      bad++;
      $display("FAIL tmo_waits(lat=%0d): got ack=%b waits=%0d want ack=1 waits=8", lat, got, waits);
    end
    total++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata} !== {2'b10, exp_err, 1'b0, exp_rd}) begin
      bad++;
      $display("FAIL tmo_resp(lat=%0d): got ack0/ack1/err0/err1/rdata %b%b%b%b/%h want 10%b0/%h",
               lat, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata, exp_err, exp_rd);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.busy, bus.ack0, bus.err0} !== 3'b000) begin
      bad++;
      $display("FAIL tmo_idle(lat=%0d): got busy/ack0/err0 %b%b%b want 000",
               lat, bus.busy, bus.ack0, bus.err0);
    end
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    logic seen;
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'd9; bus.we0 = 1'b0;
    mem_lat = 4; mem_val = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.busy, bus.mem_addr} !== {1'b1, 16'd9}) begin
      bad++;
      $display("FAIL rstw_pre: got busy/addr %b/%h want 1/0009", bus.busy, bus.mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.mem_req, bus.mem_we, bus.ack0, bus.ack1, bus.err0, bus.err1,
         bus.mem_addr, bus.mem_wdata, bus.rdata} !== 55'h0) begin
      bad++;
      $display("FAIL rstw_async: got busy=%b addr=%h rdata=%h want all 0",
               bus.busy, bus.mem_addr, bus.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstw_late_ready: got activity=%b want 0", seen);
    end
    bus.req0 = 1'b1; bus.addr0 = 16'd11;
    mem_lat = 1; mem_val = 16'h3C3C;
    wait_ack(10, cyc);
    total++;
    if ({cyc[3:0], bus.ack0, bus.err0, bus.rdata} !== {4'd3, 2'b10, 16'h3C3C}) begin
      bad++;
      $display("FAIL rstw_next: got cyc=%0d ack0/err0/rdata %b%b/%h want 3 10/3c3c",
               cyc, bus.ack0, bus.err0, bus.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_ready();
    logic seen;
    @(negedge clk);
    mem_lat = 0; mem_val = 16'hDEAD;
    inject_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.busy || bus.err0 || bus.err1) seen = 1'b1;
    end
    total++;
    if ({seen, bus.rdata} !== {1'b0, 16'h3C3C}) begin
      bad++;
      $display("FAIL idle_ready: got activity=%b rdata=%h want 0/3c3c", seen, bus.rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    @(negedge clk);
    test_reset();
    test_read();
    test_alternate();
    test_write();
    test_timeout(0, 1'b1, 16'h0000);
    test_timeout(8, 1'b0, 16'hC0DE);
    test_reset_in_wait();
    test_idle_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
